// File: rtl/fillscreen_pkg.sv
// Shared VGA screen geometry, bus widths and the fill FSM state type.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        DONE = 1'b1
    } fill_state_t;

endpackage : vga_pkg

// File: rtl/fillscreen_if.sv
// Control and plot-bus signals between the top-level FSM, the fillscreen
// sweeper and the VGA adapter.
// master: the sweeper side (takes start/colour, drives done and the plot bus).
// slave : the controller/adapter side.
interface fillscreen_if import vga_pkg::*; ();

    logic [COLOUR_W-1:0] colour;
    logic                start;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        input  colour,
        input  start,
        output done,
        output vga_x,
        output vga_y,
        output vga_colour,
        output vga_plot
    );

    modport slave (
        output colour,
        output start,
        input  done,
        input  vga_x,
        input  vga_y,
        input  vga_colour,
        input  vga_plot
    );

endinterface : fillscreen_if

// File: rtl/fillscreen_xy_scan_counter.sv
// Column-major x/y pixel scanner. On each enabled edge the row advances;
// at the bottom row it wraps to 0 and the column advances. The scan stops
// on the last pixel and never wraps past the end of the screen; a
// synchronous clear returns it to (0,0).
module xy_scan_counter import vga_pkg::*; #(
    parameter int W = SCREEN_W,
    parameter int H = SCREEN_H
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           clr,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(H - 1);

    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;
    logic           last_s;

    assign last_s = (x_r == X_LAST) && (y_r == Y_LAST);

    // Scan position: clear, column-major advance while enabled, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= {X_W{1'b0}};
            y_r <= {Y_W{1'b0}};
        end else if (clr) begin
            x_r <= {X_W{1'b0}};
            y_r <= {Y_W{1'b0}};
        end else if (en && !last_s) begin
            if (y_r < Y_LAST) begin
                y_r <= y_r + Y_W'(1);
            end else begin
                y_r <= {Y_W{1'b0}};
                x_r <= x_r + X_W'(1);
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    assign x    = x_r;
    assign y    = y_r;
    assign last = last_s;

endmodule : xy_scan_counter

// File: rtl/fillscreen.sv
// Full-screen pixel sweeper for a 160x120, 3-bit colour VGA adapter.
// While start is high it presents one pixel per clock in column-major
// order with plot high, then raises done and drops plot. Dropping start
// from the done state rearms the sweep at (0,0).
// Build option: SOLID_COLOUR_EN -- when defined, vga_colour passes the
// colour input through; otherwise vga_colour is x[2:0] (8-column stripes).
module fillscreen import vga_pkg::*; #(
    parameter int SCREEN_W_P = SCREEN_W,
    parameter int SCREEN_H_P = SCREEN_H
) (
    input  logic         clk,
    input  logic         rst_n,
    fillscreen_if.master bus
);

    fill_state_t    state_r;
    fill_state_t    state_nxt_s;
    logic           en_s;
    logic           clr_s;
    logic [X_W-1:0] x_s;
    logic [Y_W-1:0] y_s;
    logic           last_s;

    xy_scan_counter #(
        .W (SCREEN_W_P),
        .H (SCREEN_H_P)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_s),
        .clr   (clr_s),
        .x     (x_s),
        .y     (y_s),
        .last  (last_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and scanner control: advance while running, finish on the
    // last pixel, rearm once start is released after completion.
    always_comb begin
        state_nxt_s = state_r;
        en_s        = 1'b0;
        clr_s       = 1'b0;
        case (state_r)
            FILL: begin
                en_s = bus.start;
                if (bus.start && last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            DONE: begin
                if (!bus.start) begin
                    state_nxt_s = FILL;
                    clr_s       = 1'b1;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = FILL;
                clr_s       = 1'b1;
            end
        endcase
    end

    // Plot bus is decoded straight from the scan position and state so the
    // adapter sees the current pixel with zero latency.
    assign bus.vga_x    = x_s;
    assign bus.vga_y    = y_s;
    assign bus.vga_plot = (state_r == FILL);
    assign bus.done     = (state_r == DONE);

`ifdef SOLID_COLOUR_EN
    assign bus.vga_colour = bus.colour;
`else
    assign bus.vga_colour = x_s[COLOUR_W-1:0];
`endif

endmodule : fillscreen

// File: tb/tb_fillscreen.sv
// Self-checking bench for fillscreen: reset, full sweeps, completion hold,
// restart, pause/resume, asynchronous reset and a randomised start pattern,
// all against a pixel-index reference model.
module tb_fillscreen;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int NPIX  = W * H;

    logic clk;
    logic rst_n;

    fillscreen_if fsif ();

    fillscreen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fsif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: linear pixel index p (column-major) and a done flag.
    int         m_p    = 0;
    bit         m_done = 1'b0;
    logic [2:0] cur_colour = 3'b000;

    // Expected {vga_x, vga_y, vga_colour, vga_plot, done}.
    function automatic logic [19:0] model_out(input int p, input bit dn, input logic [2:0] col);
        int         x;
        int         y;
        logic [2:0] c;
        x = p / H;
        y = p % H;
`ifdef SOLID_COLOUR_EN
        c = col;
`else
        c = 3'(x % 8);
`endif
        return {8'(x), 7'(y), c, (dn ? 1'b0 : 1'b1), (dn ? 1'b1 : 1'b0)};
    endfunction

    function automatic logic [19:0] observed();
        return {fsif.vga_x, fsif.vga_y, fsif.vga_colour, fsif.vga_plot, fsif.done};
    endfunction

    // One rising edge of the model given the start level seen at that edge.
    task automatic model_edge(input bit s);
        if (!m_done) begin
            if (s) begin
                if (m_p == NPIX - 1) m_done = 1'b1;
                else                 m_p    = m_p + 1;
            end
        end else if (!s) begin
            m_done = 1'b0;
            m_p    = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        logic [19:0] e;
        rst_n      = 1'b0;
        fsif.start = 1'b0;
        cur_colour = 3'($urandom_range(7));
        fsif.colour = cur_colour;
        m_p = 0; m_done = 1'b0;
        @(posedge clk);
        #2;
        e = model_out(m_p, m_done, cur_colour);
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL reset_held got=%h want=%h", observed(), e);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL reset_release got=%h want=%h", observed(), e);
        end
    endtask

    task automatic test_full_sweep(input logic [2:0] col);
        logic [19:0] e;
        cur_colour  = col;
        fsif.colour = col;
        fsif.start  = 1'b1;
        for (int k = 0; k < NPIX; k++) begin
            tick();
            model_edge(1'b1);
            e = model_out(m_p, m_done, cur_colour);
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL sweep edge=%0d got=%h want=%h", k + 1, observed(), e);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            model_edge(1'b1);
            e = model_out(m_p, m_done, cur_colour);
            checks++;
            if (observed() !== e || fsif.done !== 1'b1) begin
                errors++;
                $display("FAIL done_hold edge=%0d got=%h want=%h", k, observed(), e);
            end
        end
    endtask

    task automatic test_restart();
        logic [19:0] e;
        fsif.start = 1'b0;
        tick();
        model_edge(1'b0);
        e = model_out(m_p, m_done, cur_colour);
        checks++;
        if (observed() !== e || fsif.vga_x !== 8'd0 || fsif.vga_plot !== 1'b1) begin
            errors++;
            $display("FAIL restart got=%h want=%h", observed(), e);
        end
        test_full_sweep(3'b101);
    endtask

    task automatic test_pause_reset();
        logic [19:0] e;
        fsif.start = 1'b0;
        tick();
        model_edge(1'b0);
        fsif.start = 1'b1;
        for (int k = 0; k < 37 * H + 54; k++) begin
            tick();
            model_edge(1'b1);
        end
        checks++;
        if (fsif.vga_x !== 8'd37 || fsif.vga_y !== 7'd54 || fsif.vga_plot !== 1'b1) begin
            errors++;
            $display("FAIL pause_reach got=%0d,%0d want=37,54", fsif.vga_x, fsif.vga_y);
        end
        fsif.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            model_edge(1'b0);
            e = model_out(m_p, m_done, cur_colour);
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL pause_hold edge=%0d got=%h want=%h", k, observed(), e);
            end
        end
        fsif.start = 1'b1;
        tick();
        model_edge(1'b1);
        checks++;
        if (fsif.vga_x !== 8'd37 || fsif.vga_y !== 7'd55) begin
            errors++;
            $display("FAIL resume got=%0d,%0d want=37,55", fsif.vga_x, fsif.vga_y);
        end
        #1;
        rst_n = 1'b0;
        #1;
        m_p = 0; m_done = 1'b0;
        e = model_out(m_p, m_done, cur_colour);
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", observed(), e);
        end
        fsif.start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_random_start();
        logic [19:0] e;
        bit          s;
        for (int k = 0; k < 22000; k++) begin
            s           = ($urandom_range(15) != 0);
            cur_colour  = 3'($urandom_range(7));
            fsif.start  = s;
            fsif.colour = cur_colour;
            tick();
            model_edge(s);
            e = model_out(m_p, m_done, cur_colour);
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", k, observed(), e);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        fsif.start  = 1'b0;
        fsif.colour = 3'b000;
        test_reset();
        test_full_sweep(3'b101);
        test_restart();
        test_pause_reset();
        test_random_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

endmodule : tb_fillscreen
